// File: rtl/pcievdm_nios_avmm_arb.sv
// Round-robin arbiter sharing the PCIe VDM buffer NIOS AVMM slave.
// One command in flight; read watchdog counts pulse_1ms ticks.
module pcievdm_nios_avmm_arb #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_MS = 4,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_1ms,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic                  m0_read,
  input  logic [DATA_WIDTH-1:0] m0_wrdata,
  output logic [DATA_WIDTH-1:0] m0_rddata,
  output logic                  m0_rddvld,
  output logic                  m0_waitreq,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic                  m1_read,
  input  logic [DATA_WIDTH-1:0] m1_wrdata,
  output logic [DATA_WIDTH-1:0] m1_rddata,
  output logic                  m1_rddvld,
  output logic                  m1_waitreq,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_write,
  output logic                  s_read,
  output logic [DATA_WIDTH-1:0] s_wrdata,
  input  logic [DATA_WIDTH-1:0] s_rddata,
  input  logic                  s_rddvld,
  input  logic                  s_waitreq,
  input  logic                  err_clr,
  output logic                  rd_timeout_err,
  output logic [7:0]            late_rsp_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    RDW  = 2'd2
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_MS);

  state_t                  state;
  logic                    grant;
  logic                    last_grant;
  logic [7:0]              wd_cnt;

  logic                    req0;
  logic                    req1;
  logic                    next_grant;
  logic                    in_gnt;
  logic                    in_rdw;
  logic                    g_write;
  logic                    g_read;
  logic                    g_req;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wrdata;
  logic                    timeout_hit;
  logic                    rsp_vld;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    late;
  logic [7:0]              late_base;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // Under contention alternate away from the last accepted master.
  assign next_grant = (req0 & req1) ? ~last_grant : req1;

  assign in_gnt = (state == GNT);
  assign in_rdw = (state == RDW);

  // Write dominates a simultaneous read on the same master.
  assign g_write  = grant ? m1_write : m0_write;
  assign g_read   = (grant ? m1_read : m0_read) & ~g_write;
  assign g_req    = g_write | g_read;
  assign g_addr   = grant ? m1_addr : m0_addr;
  assign g_wrdata = grant ? m1_wrdata : m0_wrdata;

  assign s_addr   = in_gnt ? g_addr : '0;
  assign s_wrdata = in_gnt ? g_wrdata : '0;
  assign s_write  = in_gnt & g_write;
  assign s_read   = in_gnt & g_read;

  assign m0_waitreq = (in_gnt & ~grant) ? s_waitreq : 1'b1;
  assign m1_waitreq = (in_gnt & grant) ? s_waitreq : 1'b1;

  // Real data beats a timeout landing on the same cycle.
  assign timeout_hit = in_rdw & pulse_1ms & ~s_rddvld &
                       (wd_cnt == TO_CNT);
  assign rsp_vld  = in_rdw & (s_rddvld | timeout_hit);
  assign rsp_data = s_rddvld ? s_rddata : TIMEOUT_DATA;

  assign m0_rddvld = rsp_vld & ~grant;
  assign m1_rddvld = rsp_vld & grant;
  assign m0_rddata = m0_rddvld ? rsp_data : '0;
  assign m1_rddata = m1_rddvld ? rsp_data : '0;

  assign late      = s_rddvld & ~in_rdw;
  assign late_base = err_clr ? 8'd0 : late_rsp_cnt;

  // Arbitration and transaction sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wd_cnt     <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= next_grant;
            state <= GNT;
          end
        end
        GNT: begin
          if (!g_req) begin
            state <= IDLE;
          end else if (!s_waitreq) begin
            last_grant <= grant;
            if (g_write) begin
              state <= IDLE;
            end else begin
              state  <= RDW;
              wd_cnt <= 8'd0;
            end
          end
        end
        RDW: begin
          if (s_rddvld | timeout_hit) begin
            state <= IDLE;
          end else if (pulse_1ms) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky debug status; a set event overrides err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_timeout_err <= 1'b0;
      late_rsp_cnt   <= 8'd0;
    end else begin
      if (timeout_hit) begin
        rd_timeout_err <= 1'b1;
      end else if (err_clr) begin
        rd_timeout_err <= 1'b0;
      end
      if (late) begin
        late_rsp_cnt <= (late_base == 8'hFF) ? late_base
                                             : late_base + 8'd1;
      end else if (err_clr) begin
        late_rsp_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_pcievdm_nios_avmm_arb.sv
// Directed bench for pcievdm_nios_avmm_arb.
// Checks arbitration, backpressure, watchdog and status.
module tb_pcievdm_nios_avmm_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse_1ms;
  logic [8:0]  m0_addr, m1_addr, s_addr;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [31:0] m0_wrdata, m1_wrdata, m0_rddata, m1_rddata;
  logic        m0_rddvld, m1_rddvld, m0_waitreq, m1_waitreq;
  logic        s_write, s_read, s_rddvld, s_waitreq;
  logic [31:0] s_wrdata, s_rddata;
  logic        err_clr, rd_timeout_err;
  logic [7:0]  late_rsp_cnt;

  int compared = 0;
  int mismatched = 0;

  pcievdm_nios_avmm_arb dut (
    .clk(clk), .reset(reset), .pulse_1ms(pulse_1ms),
    .m0_addr(m0_addr), .m0_write(m0_write), .m0_read(m0_read),
    .m0_wrdata(m0_wrdata), .m0_rddata(m0_rddata),
    .m0_rddvld(m0_rddvld), .m0_waitreq(m0_waitreq),
    .m1_addr(m1_addr), .m1_write(m1_write), .m1_read(m1_read),
    .m1_wrdata(m1_wrdata), .m1_rddata(m1_rddata),
    .m1_rddvld(m1_rddvld), .m1_waitreq(m1_waitreq),
    .s_addr(s_addr), .s_write(s_write), .s_read(s_read),
    .s_wrdata(s_wrdata), .s_rddata(s_rddata),
    .s_rddvld(s_rddvld), .s_waitreq(s_waitreq),
    .err_clr(err_clr), .rd_timeout_err(rd_timeout_err),
    .late_rsp_cnt(late_rsp_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pulse_1ms = 0; err_clr = 0;
    m0_addr = '0; m1_addr = '0; m0_wrdata = '0; m1_wrdata = '0;
    m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
    s_rddata = '0; s_rddvld = 0; s_waitreq = 0;
    #12;
    compared++;
    if ({m0_waitreq, m1_waitreq, m0_rddvld, m1_rddvld} !== 4'b1100) begin
      mismatched++;
      $display("FAIL rst_mst got %b exp 1100",
               {m0_waitreq, m1_waitreq, m0_rddvld, m1_rddvld});
    end
    compared++;
    if ({s_write, s_read, s_addr, s_wrdata} !== '0) begin
      mismatched++;
      $display("FAIL rst_slv got w%b r%b a%h d%h exp 0",
               s_write, s_read, s_addr, s_wrdata);
    end
    compared++;
    if ({m0_rddata, m1_rddata, rd_timeout_err, late_rsp_cnt} !== '0) begin
      mismatched++;
      $display("FAIL rst_misc got %h %h %b %0d exp 0",
               m0_rddata, m1_rddata, rd_timeout_err, late_rsp_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    logic [8:0]  ea;
    logic        g;
    logic [31:0] d;
    m0_addr = 9'h020; m1_addr = 9'h030;
    m0_read = 1; m1_read = 1; s_waitreq = 0;
    for (int r = 0; r < 4; r++) begin
      g  = r[0];
      ea = g ? 9'h030 : 9'h020;
      d  = 32'hA000_0000 + r;
      tick;
      compared++;
      if ({s_read, s_addr, m0_waitreq, m1_waitreq} !== {1'b1, ea, g, ~g}) begin
        mismatched++;
        $display("FAIL cont_gnt%0d got r%b a%h w0%b w1%b exp a%h g%b",
                 r, s_read, s_addr, m0_waitreq, m1_waitreq, ea, g);
      end
      tick;
      compared++;
      if ({s_read, m0_waitreq, m1_waitreq} !== 3'b011) begin
        mismatched++;
        $display("FAIL cont_rdw%0d got r%b w0%b w1%b exp 011",
                 r, s_read, m0_waitreq, m1_waitreq);
      end
      tick; tick; tick;
      s_rddvld = 1; s_rddata = d;
      #1;
      compared++;
      if ({m0_rddvld, m1_rddvld} !== {~g, g} ||
          (g ? m1_rddata : m0_rddata) !== d ||
          (g ? m0_rddata : m1_rddata) !== 32'h0) begin
        mismatched++;
        $display("FAIL cont_rsp%0d got v%b%b d0%h d1%h exp g%b d%h",
                 r, m0_rddvld, m1_rddvld, m0_rddata, m1_rddata, g, d);
      end
      tick;
      s_rddvld = 0;
    end
    m0_read = 0; m1_read = 0;
    #1;
    compared++;
    if (late_rsp_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL cont_late got %0d exp 0", late_rsp_cnt);
    end
  endtask

  task automatic test_single_write;
    m0_addr = 9'h010; m0_wrdata = 32'h1234_5678; m0_write = 1;
    s_waitreq = 0;
    tick;
    compared++;
    if ({s_write, s_read, s_addr, s_wrdata, m0_waitreq, m1_waitreq}
        !== {2'b10, 9'h010, 32'h1234_5678, 2'b01}) begin
      mismatched++;
      $display("FAIL wr_cmd got w%b r%b a%h d%h w0%b w1%b",
               s_write, s_read, s_addr, s_wrdata, m0_waitreq, m1_waitreq);
    end
    tick;
    m0_write = 0;
    #1;
    compared++;
    if ({s_write, m0_waitreq, m1_waitreq} !== 3'b011) begin
      mismatched++;
      $display("FAIL wr_done got w%b w0%b w1%b exp 011",
               s_write, m0_waitreq, m1_waitreq);
    end
    tick;
  endtask

  task automatic test_backpressure;
    m1_addr = 9'h055; m1_wrdata = 32'hCAFE_F00D; m1_write = 1;
    m0_addr = 9'h044; m0_read = 1;
    s_waitreq = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      compared++;
      if ({s_write, s_read, s_addr, s_wrdata, m0_waitreq, m1_waitreq}
          !== {2'b10, 9'h055, 32'hCAFE_F00D, 2'b11}) begin
        mismatched++;
        $display("FAIL bp_hold%0d got w%b r%b a%h d%h w0%b w1%b", i,
                 s_write, s_read, s_addr, s_wrdata, m0_waitreq, m1_waitreq);
      end
    end
    s_waitreq = 0;
    #1;
    compared++;
    if ({m0_waitreq, m1_waitreq} !== 2'b10) begin
      mismatched++;
      $display("FAIL bp_acc got w0%b w1%b exp 10", m0_waitreq, m1_waitreq);
    end
    tick;
    m1_write = 0;
    #1;
    compared++;
    if ({s_write, s_read} !== 2'b00) begin
      mismatched++;
      $display("FAIL bp_idle got w%b r%b exp 00", s_write, s_read);
    end
    tick;
    compared++;
    if ({s_read, s_addr, m0_waitreq} !== {1'b1, 9'h044, 1'b0}) begin
      mismatched++;
      $display("FAIL bp_m0gnt got r%b a%h w0%b", s_read, s_addr, m0_waitreq);
    end
    m0_read = 0;
    tick;
    compared++;
    if ({s_read, s_write, m0_waitreq} !== 3'b001) begin
      mismatched++;
      $display("FAIL bp_drop got r%b w%b w0%b exp 001",
               s_read, s_write, m0_waitreq);
    end
    tick;
    compared++;
    if ({s_read, s_write} !== 2'b00) begin
      mismatched++;
      $display("FAIL bp_drop2 got r%b w%b exp 00", s_read, s_write);
    end
  endtask

  task automatic test_timeout;
    m0_addr = 9'h007; m0_read = 1; s_waitreq = 0;
    tick;
    tick;
    m0_read = 0;
    for (int k = 1; k <= 5; k++) begin
      pulse_1ms = 1;
      #1;
      compared++;
      if (k < 5 && {m0_rddvld, m1_rddvld} !== 2'b00) begin
        mismatched++;
        $display("FAIL to_early%0d got v%b%b exp 00", k, m0_rddvld, m1_rddvld);
      end else if (k == 5 && ({m0_rddvld, m1_rddvld} !== 2'b10 ||
                              m0_rddata !== 32'hDEAD_BEEF)) begin
        mismatched++;
        $display("FAIL to_fire got v%b%b d%h exp 10 deadbeef",
                 m0_rddvld, m1_rddvld, m0_rddata);
      end
      tick;
      pulse_1ms = 0;
    end
    #1;
    compared++;
    if ({rd_timeout_err, m0_rddvld} !== 2'b10) begin
      mismatched++;
      $display("FAIL to_err got e%b v%b exp 10", rd_timeout_err, m0_rddvld);
    end
    err_clr = 1;
    tick;
    err_clr = 0;
    #1;
    compared++;
    if (rd_timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL to_clr got %b exp 0", rd_timeout_err);
    end
  endtask

  task automatic test_late;
    s_rddvld = 1; s_rddata = 32'h5555_AAAA;
    #1;
    compared++;
    if ({m0_rddvld, m1_rddvld, m0_rddata, m1_rddata} !== '0) begin
      mismatched++;
      $display("FAIL late_drop got v%b%b d%h %h exp 0",
               m0_rddvld, m1_rddvld, m0_rddata, m1_rddata);
    end
    tick;
    s_rddvld = 0;
    #1;
    compared++;
    if (late_rsp_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL late_one got %0d exp 1", late_rsp_cnt);
    end
    s_rddvld = 1;
    repeat (300) tick;
    s_rddvld = 0;
    #1;
    compared++;
    if (late_rsp_cnt !== 8'd255) begin
      mismatched++;
      $display("FAIL late_sat got %0d exp 255", late_rsp_cnt);
    end
  endtask

  task automatic test_timeout_race;
    m0_addr = 9'h008; m0_read = 1; s_waitreq = 0;
    tick;
    tick;
    m0_read = 0;
    for (int k = 1; k <= 4; k++) begin
      pulse_1ms = 1;
      tick;
      pulse_1ms = 0;
    end
    pulse_1ms = 1; s_rddvld = 1; s_rddata = 32'h1111_2222;
    #1;
    compared++;
    if ({m0_rddvld, m1_rddvld} !== 2'b10 || m0_rddata !== 32'h1111_2222) begin
      mismatched++;
      $display("FAIL race_data got v%b%b d%h exp 10 11112222",
               m0_rddvld, m1_rddvld, m0_rddata);
    end
    tick;
    pulse_1ms = 0; s_rddvld = 0;
    #1;
    compared++;
    if ({rd_timeout_err, late_rsp_cnt} !== {1'b0, 8'd255}) begin
      mismatched++;
      $display("FAIL race_err got e%b c%0d exp 0 255",
               rd_timeout_err, late_rsp_cnt);
    end
  endtask

  task automatic test_reset_rdw;
    m0_addr = 9'h0AA; m1_addr = 9'h0BB; m1_read = 1; s_waitreq = 0;
    tick;
    tick;
    m1_read = 0;
    #2;
    reset = 1;
    #1;
    compared++;
    if ({s_read, s_write, s_addr, m0_waitreq, m1_waitreq,
         rd_timeout_err, late_rsp_cnt} !== {2'b00, 9'h0, 2'b11, 1'b0, 8'd0}) begin
      mismatched++;
      $display("FAIL rrdw_async got r%b w%b a%h w%b%b e%b c%0d",
               s_read, s_write, s_addr, m0_waitreq, m1_waitreq,
               rd_timeout_err, late_rsp_cnt);
    end
    tick;
    reset = 0;
    s_rddvld = 1; s_rddata = 32'h7777_7777;
    #1;
    compared++;
    if ({m0_rddvld, m1_rddvld} !== 2'b00) begin
      mismatched++;
      $display("FAIL rrdw_drop got v%b%b exp 00", m0_rddvld, m1_rddvld);
    end
    tick;
    s_rddvld = 0;
    #1;
    compared++;
    if (late_rsp_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL rrdw_late got %0d exp 1", late_rsp_cnt);
    end
    m0_read = 1; m1_read = 1;
    tick;
    compared++;
    if ({s_read, s_addr, m0_waitreq, m1_waitreq}
        !== {1'b1, 9'h0AA, 2'b01}) begin
      mismatched++;
      $display("FAIL rrdw_m0first got r%b a%h w%b%b exp a0aa w01",
               s_read, s_addr, m0_waitreq, m1_waitreq);
    end
    m0_read = 0; m1_read = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_contention;
    test_single_write;
    test_backpressure;
    test_timeout;
    test_late;
    test_timeout_race;
    test_reset_rdw;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
